// File: rtl/cdc_hs_pkg.sv
// Shared types and helpers for the req/ack clock-domain handshake blocks.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    HS_IDLE   = 2'd0,
    HS_REQ_HI = 2'd1,
    HS_REQ_LO = 2'd2
  } hs_state_t;

  // Timer wide enough to hold TIMEOUT; a disabled timeout still gets one bit.
  function automatic int timer_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/sync_level_sreset.sv
// N-flop level synchronizer with synchronous active-high reset; shared by the
// ack path here and the req path in the matching receiver.
module sync_level_sreset #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [N-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], async_in};
    end
  end

  assign sync_out = sync_q[N-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-domain end of a 4-phase req/ack crossing: captures a word, holds it on
// xfer_data while xfer_req is high, and completes once the synchronized ack falls.
module cdc_handshake_tx
  import cdc_hs_pkg::*;
#(
  parameter int N       = 2,
  parameter int W       = 32,
  parameter int TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         send_valid,
  output logic         send_ready,
  input  logic [W-1:0] send_data,
  output logic         xfer_req,
  output logic [W-1:0] xfer_data,
  input  logic         xfer_ack_async,
  output logic         done,
  output logic         err
);

  localparam int            TW         = timer_width(TIMEOUT);
  localparam logic [TW-1:0] TIMER_MAX  = '1;
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  hs_state_t     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [W-1:0]  data_d;
  logic          req_d, done_d, err_d;
  logic          ack_s;

  sync_level_sreset #(.N(N)) u_ack_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (xfer_ack_async),
    .sync_out (ack_s)
  );

  assign send_ready = (state_q == HS_IDLE);

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    data_d  = xfer_data;
    req_d   = xfer_req;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      HS_IDLE: begin
        if (send_valid) begin
          data_d  = send_data;
          req_d   = 1'b1;
          timer_d = '0;
          state_d = HS_REQ_HI;
        end
      end
      HS_REQ_HI: begin
        if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
        // A synchronized ack takes priority over a timeout expiring in the same cycle.
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = HS_REQ_LO;
        end else if ((TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = HS_REQ_LO;
        end
      end
      HS_REQ_LO: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = HS_IDLE;
        end
      end
      default: state_d = HS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HS_IDLE;
      timer_q   <= '0;
      xfer_data <= '0;
      xfer_req  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      xfer_data <= data_d;
      xfer_req  <= req_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Randomized self-checking bench: a behavioural far-side responder plus an
// accept/done scoreboard checked against handshake latency arithmetic.
module tb_cdc_handshake_tx;

  localparam int N       = 2;
  localparam int W       = 8;
  localparam int TIMEOUT = 16;
  localparam int LAT0    = 2 * N + 3;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } ev_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         send_valid = 1'b0;
  logic         send_ready;
  logic [W-1:0] send_data = '0;
  logic         xfer_req;
  logic [W-1:0] xfer_data;
  logic         xfer_ack_async = 1'b0;
  logic         done;
  logic         err;

  logic         sv0 = 1'b0;
  logic         sr0;
  logic [W-1:0] sd0 = '0;
  logic         req0;
  logic [W-1:0] xd0;
  logic         ack0 = 1'b0;
  logic         done0;
  logic         err0;

  always #5 clk = ~clk;

  cdc_handshake_tx #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .send_valid     (send_valid),
    .send_ready     (send_ready),
    .send_data      (send_data),
    .xfer_req       (xfer_req),
    .xfer_data      (xfer_data),
    .xfer_ack_async (xfer_ack_async),
    .done           (done),
    .err            (err)
  );

  cdc_handshake_tx #(.N(N), .W(W), .TIMEOUT(0)) dut0 (
    .clk            (clk),
    .reset          (reset),
    .send_valid     (sv0),
    .send_ready     (sr0),
    .send_data      (sd0),
    .xfer_req       (req0),
    .xfer_data      (xd0),
    .xfer_ack_async (ack0),
    .done           (done0),
    .err            (err0)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Far side: raise ack ack_dly cycles after seeing req high, drop it drop_dly
  // cycles after seeing req low; ack_block withholds the ack entirely.
  int ack_dly = 0, drop_dly = 0, hi_cnt = 0, lo_cnt = 0;
  bit ack_block = 1'b0;
  always @(posedge clk) begin
    #2;
    if (xfer_req) begin
      lo_cnt = 0;
      if (!ack_block && hi_cnt >= ack_dly) xfer_ack_async = 1'b1;
      hi_cnt++;
    end else begin
      hi_cnt = 0;
      if (lo_cnt >= drop_dly) xfer_ack_async = 1'b0;
      lo_cnt++;
    end
  end

  ev_t          acc_q[$];
  ev_t          done_q[$];
  int           err_q[$];
  ev_t          mon_e;
  logic         err_req_last = 1'b1;
  logic         prev_ready = 1'b1;
  logic [W-1:0] prev_data = '0;
  int           stab_viol = 0;
  int           done0_cnt = 0, err0_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (send_valid && send_ready) begin
        mon_e.data = send_data; mon_e.cyc = cyc; acc_q.push_back(mon_e);
      end
      if (done) begin
        mon_e.data = xfer_data; mon_e.cyc = cyc; done_q.push_back(mon_e);
      end
      if (err) begin
        err_q.push_back(cyc); err_req_last = xfer_req;
      end
      if (!prev_ready && xfer_data !== prev_data) stab_viol++;
      if (done0) done0_cnt++;
      if (err0) err0_cnt++;
    end
    prev_ready = send_ready;
    prev_data  = xfer_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] d, output int acc_cyc);
    int n;
    n = acc_q.size();
    send_valid = 1'b1;
    send_data  = d;
    for (int i = 0; i < 300 && acc_q.size() == n; i++) step();
    total_cnt++;
    if (acc_q.size() == n) begin
      $display("FAIL accept_%h: no accept within 300 cycles", d);
      acc_cyc = -1;
    end else begin
      pass_cnt++;
      acc_cyc = acc_q[n].cyc;
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget && done_q.size() < n; i++) step();
    total_cnt++;
    if (done_q.size() < n) $display("FAIL wait_done: got %0d done pulses, want %0d", done_q.size(), n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    total_cnt++; if (send_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", send_ready); else pass_cnt++;
    total_cnt++; if (xfer_req !== 1'b0) $display("FAIL reset_req: got %b want 0", xfer_req); else pass_cnt++;
    total_cnt++; if (xfer_data !== 8'h00) $display("FAIL reset_data: got %h want 00", xfer_data); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
    total_cnt++; if (sr0 !== 1'b1 || req0 !== 1'b0) $display("FAIL reset_dut0: got ready=%b req=%b want 1/0", sr0, req0); else pass_cnt++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int a0, nd, ne, sv, got_cyc;
    logic [W-1:0] got_data;
    ack_dly = 1; drop_dly = 1; ack_block = 1'b0;
    nd = done_q.size(); ne = err_q.size(); sv = stab_viol;
    send_word(8'hA5, a0);
    send_valid = 1'b0;
    wait_done(nd + 1, 100);
    repeat (2) step();
    got_data = 'x; got_cyc = -1;
    if (done_q.size() > nd) begin got_data = done_q[nd].data; got_cyc = done_q[nd].cyc; end
    total_cnt++; if (done_q.size() != nd + 1) $display("FAIL basic_done_count: got %0d want %0d", done_q.size() - nd, 1); else pass_cnt++;
    total_cnt++; if (got_data !== 8'hA5) $display("FAIL basic_data: got %h want a5", got_data); else pass_cnt++;
    total_cnt++; if (got_cyc - a0 != 2 + LAT0) $display("FAIL basic_latency: got %0d want %0d", got_cyc - a0, 2 + LAT0); else pass_cnt++;
    total_cnt++; if (err_q.size() != ne) $display("FAIL basic_err: got %0d err pulses want 0", err_q.size() - ne); else pass_cnt++;
    total_cnt++; if (stab_viol != sv) $display("FAIL basic_stable: got %0d data changes while busy want 0", stab_viol - sv); else pass_cnt++;
    total_cnt++; if (send_ready !== 1'b1) $display("FAIL basic_ready: got %b want 1", send_ready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int ac[3];
    int na, nd, got_cyc;
    logic [W-1:0] got_data;
    ack_dly = 0; drop_dly = 0;
    na = acc_q.size(); nd = done_q.size();
    send_word(8'h01, ac[0]);
    send_word(8'h02, ac[1]);
    send_word(8'h03, ac[2]);
    send_valid = 1'b0;
    wait_done(nd + 3, 200);
    repeat (3) step();
    total_cnt++; if (acc_q.size() - na != 3) $display("FAIL b2b_accepts: got %0d want 3", acc_q.size() - na); else pass_cnt++;
    total_cnt++; if (done_q.size() - nd != 3) $display("FAIL b2b_dones: got %0d want 3", done_q.size() - nd); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      got_data = 'x; got_cyc = -1;
      if (done_q.size() > nd + i) begin got_data = done_q[nd + i].data; got_cyc = done_q[nd + i].cyc; end
      total_cnt++; if (got_data !== W'(i + 1)) $display("FAIL b2b_data%0d: got %h want %h", i, got_data, W'(i + 1)); else pass_cnt++;
      total_cnt++; if (got_cyc - ac[i] != LAT0) $display("FAIL b2b_latency%0d: got %0d want %0d", i, got_cyc - ac[i], LAT0); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int a0, nd, ne, sv, got_cyc, exp_lat;
    logic [W-1:0] d, got_data;
    ack_block = 1'b0;
    ne = err_q.size(); sv = stab_viol;
    for (int t = 0; t < 12; t++) begin
      ack_dly  = $urandom_range(0, 6);
      drop_dly = $urandom_range(0, 6);
      exp_lat  = ack_dly + drop_dly + LAT0;
      d        = W'($urandom);
      repeat ($urandom_range(0, 3)) step();
      nd = done_q.size();
      send_word(d, a0);
      send_valid = 1'b0;
      wait_done(nd + 1, 100);
      got_data = 'x; got_cyc = -1;
      if (done_q.size() > nd) begin got_data = done_q[nd].data; got_cyc = done_q[nd].cyc; end
      total_cnt++; if (got_data !== d) $display("FAIL rand%0d_data: got %h want %h", t, got_data, d); else pass_cnt++;
      total_cnt++; if (got_cyc - a0 != exp_lat) $display("FAIL rand%0d_latency: got %0d want %0d", t, got_cyc - a0, exp_lat); else pass_cnt++;
    end
    total_cnt++; if (err_q.size() != ne) $display("FAIL rand_err: got %0d err pulses want 0", err_q.size() - ne); else pass_cnt++;
    total_cnt++; if (stab_viol != sv) $display("FAIL rand_stable: got %0d data changes while busy want 0", stab_viol - sv); else pass_cnt++;
  endtask

  // Synchronized ack landing exactly on the last timer cycle wins; one cycle later loses.
  task automatic test_ack_vs_timeout();
    int a0, nd, ne, got_cyc;
    ack_block = 1'b0; drop_dly = 0;
    ack_dly = TIMEOUT - 1 - N;
    nd = done_q.size(); ne = err_q.size();
    send_word(8'h5A, a0);
    send_valid = 1'b0;
    wait_done(nd + 1, 100);
    got_cyc = (done_q.size() > nd) ? done_q[nd].cyc : -1;
    total_cnt++; if (err_q.size() != ne) $display("FAIL tie_err: got %0d err pulses want 0", err_q.size() - ne); else pass_cnt++;
    total_cnt++; if (got_cyc - a0 != ack_dly + LAT0) $display("FAIL tie_latency: got %0d want %0d", got_cyc - a0, ack_dly + LAT0); else pass_cnt++;
    ack_dly = TIMEOUT - N;
    nd = done_q.size(); ne = err_q.size();
    send_word(8'hC3, a0);
    send_valid = 1'b0;
    wait_done(nd + 1, 100);
    total_cnt++; if (err_q.size() != ne + 1) $display("FAIL late_ack_err: got %0d err pulses want 1", err_q.size() - ne); else pass_cnt++;
    repeat (4) step();
  endtask

  task automatic test_timeout();
    int a0, nd, ne, got_err, got_cyc;
    logic [W-1:0] got_data;
    ack_block = 1'b1;
    nd = done_q.size(); ne = err_q.size();
    send_word(8'h3C, a0);
    send_valid = 1'b0;
    wait_done(nd + 1, 100);
    step();
    got_err = (err_q.size() > ne) ? err_q[ne] : -1;
    got_data = 'x; got_cyc = -1;
    if (done_q.size() > nd) begin got_data = done_q[nd].data; got_cyc = done_q[nd].cyc; end
    total_cnt++; if (err_q.size() != ne + 1) $display("FAIL to_err_count: got %0d want 1", err_q.size() - ne); else pass_cnt++;
    total_cnt++; if (got_err - a0 != 1 + TIMEOUT) $display("FAIL to_err_cycle: got %0d want %0d", got_err - a0, 1 + TIMEOUT); else pass_cnt++;
    total_cnt++; if (err_req_last !== 1'b0) $display("FAIL to_req_at_err: got %b want 0", err_req_last); else pass_cnt++;
    total_cnt++; if (got_cyc - a0 != 2 + TIMEOUT) $display("FAIL to_done_cycle: got %0d want %0d", got_cyc - a0, 2 + TIMEOUT); else pass_cnt++;
    total_cnt++; if (got_data !== 8'h3C) $display("FAIL to_done_data: got %h want 3c", got_data); else pass_cnt++;
    total_cnt++; if (send_ready !== 1'b1) $display("FAIL to_ready: got %b want 1", send_ready); else pass_cnt++;
    ack_block = 1'b0;
  endtask

  task automatic test_no_timeout();
    int drops, nd0, ne0;
    nd0 = done0_cnt; ne0 = err0_cnt; drops = 0;
    ack0 = 1'b0;
    sv0 = 1'b1; sd0 = 8'h5C;
    total_cnt++; if (sr0 !== 1'b1) $display("FAIL nto_ready: got %b want 1", sr0); else pass_cnt++;
    step();
    sv0 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (req0 !== 1'b1) drops++;
      step();
    end
    total_cnt++; if (drops != 0) $display("FAIL nto_req_held: got %0d cycles with req low want 0", drops); else pass_cnt++;
    total_cnt++; if (err0_cnt != ne0) $display("FAIL nto_err: got %0d err pulses want 0", err0_cnt - ne0); else pass_cnt++;
    total_cnt++; if (xd0 !== 8'h5C) $display("FAIL nto_data: got %h want 5c", xd0); else pass_cnt++;
    ack0 = 1'b1;
    for (int i = 0; i < 20 && req0 !== 1'b0; i++) step();
    total_cnt++; if (req0 !== 1'b0) $display("FAIL nto_req_fall: got %b want 0", req0); else pass_cnt++;
    ack0 = 1'b0;
    for (int i = 0; i < 20 && done0_cnt == nd0; i++) step();
    step();
    total_cnt++; if (done0_cnt != nd0 + 1) $display("FAIL nto_done: got %0d done pulses want 1", done0_cnt - nd0); else pass_cnt++;
    total_cnt++; if (sr0 !== 1'b1 || err0_cnt != ne0) $display("FAIL nto_end: got ready=%b errs=%0d want 1/0", sr0, err0_cnt - ne0); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int a0, nd, ne;
    ack_block = 1'b1;
    send_word(8'h77, a0);
    send_valid = 1'b0;
    repeat (5) step();
    nd = done_q.size(); ne = err_q.size();
    total_cnt++; if (xfer_req !== 1'b1) $display("FAIL mid_pre_req: got %b want 1", xfer_req); else pass_cnt++;
    reset = 1'b1;
    step();
    total_cnt++; if (xfer_req !== 1'b0) $display("FAIL mid_req: got %b want 0", xfer_req); else pass_cnt++;
    total_cnt++; if (send_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", send_ready); else pass_cnt++;
    total_cnt++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL mid_pulses: got done=%b err=%b want 0/0", done, err); else pass_cnt++;
    total_cnt++; if (xfer_data !== 8'h00) $display("FAIL mid_data: got %h want 00", xfer_data); else pass_cnt++;
    step();
    reset = 1'b0;
    repeat (6) step();
    total_cnt++; if (done_q.size() != nd || err_q.size() != ne) $display("FAIL mid_after: got done=%0d err=%0d want 0/0", done_q.size() - nd, err_q.size() - ne); else pass_cnt++;
    total_cnt++; if (send_ready !== 1'b1) $display("FAIL mid_after_ready: got %b want 1", send_ready); else pass_cnt++;
    ack_block = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_random();
    test_ack_vs_timeout();
    test_timeout();
    test_no_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
